// File: rtl/vga_plot_arb.sv
// vga_plot_arb: arbitrates two pixel requesters and a screen clear onto one Avalon write master
module vga_plot_arb #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        r0_valid,
   input  logic        r1_valid,
   output logic        r0_ready,
   output logic        r1_ready,
   input  logic [7:0]  r0_x,
   input  logic [6:0]  r0_y,
   input  logic [7:0]  r0_colour,
   input  logic [7:0]  r1_x,
   input  logic [6:0]  r1_y,
   input  logic [7:0]  r1_colour,
   input  logic        clear_start,
   input  logic [7:0]  clear_colour,
   output logic        busy_clearing,
   output logic [3:0]  avm_address,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   output logic [15:0] drop_count
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;
   localparam logic [8:0] W_LIM = 9'(SCREEN_W);
   localparam logic [7:0] H_LIM = 8'(SCREEN_H);
   localparam logic [7:0] W_MAX = 8'(SCREEN_W - 1);
   localparam logic [6:0] H_MAX = 7'(SCREEN_H - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic [7:0]  r_colour;
   logic [7:0]  r_cx;
   logic [6:0]  r_cy;
   logic [7:0]  r_clr_colour;
   logic        r_clr_pending;
   logic        r_last_grant;
   logic [15:0] r_drop;
   logic        w_open;
   logic        w_g0;
   logic        w_g1;
   logic        w_xfer;
   logic [7:0]  w_x;
   logic [6:0]  w_y;
   logic [7:0]  w_colour;
   logic        w_in_range;
   logic        w_clr_last;
   logic        w_enter_clear;

   // A clear request in the same cycle beats any pixel request; readies are also held low in reset.
   assign w_open     = reset_n && r_state == S_IDLE && !r_clr_pending && !clear_start;
   assign w_g1       = r1_valid && (!r0_valid || !r_last_grant);
   assign w_g0       = r0_valid && !w_g1;
   assign r0_ready   = w_open && w_g0;
   assign r1_ready   = w_open && w_g1;
   assign w_xfer     = r0_ready || r1_ready;
   assign w_x        = w_g1 ? r1_x : r0_x;
   assign w_y        = w_g1 ? r1_y : r0_y;
   assign w_colour   = w_g1 ? r1_colour : r0_colour;
   assign w_in_range = ({1'b0, w_x} < W_LIM) && ({1'b0, w_y} < H_LIM);
   assign w_clr_last = r_cx == W_MAX && r_cy == H_MAX;
   assign w_enter_clear = r_state != S_CLEAR && w_next == S_CLEAR;
   assign avm_address = 4'd0;
   assign drop_count  = r_drop;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state: a pending clear is taken from IDLE, or once the outstanding pixel write completes.
   always_comb begin
      w_next = (r_state == S_IDLE)  ? (r_clr_pending ? S_CLEAR : (w_xfer && w_in_range) ? S_ISSUE : S_IDLE) :
               (r_state == S_ISSUE) ? (avm_waitrequest ? S_ISSUE : r_clr_pending ? S_CLEAR : S_IDLE) :
               (r_state == S_CLEAR) ? ((!avm_waitrequest && w_clr_last) ? S_IDLE : S_CLEAR) : S_IDLE;
   end

   // Outputs are pure functions of state and the latched write fields, so they stay stable under stall.
   always_comb begin
      avm_write     = r_state == S_ISSUE || r_state == S_CLEAR;
      busy_clearing = r_clr_pending || r_state == S_CLEAR;
      avm_writedata = (r_state == S_ISSUE) ? {1'b0, r_y, r_x, 8'd0, r_colour} :
                      (r_state == S_CLEAR) ? {1'b0, r_cy, r_cx, 8'd0, r_clr_colour} : 32'd0;
   end

   // Datapath: pixel latch, round-robin history, drop counter, clear bookkeeping and raster scan.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x           <= '0;
         r_y           <= '0;
         r_colour      <= '0;
         r_cx          <= '0;
         r_cy          <= '0;
         r_clr_colour  <= '0;
         r_clr_pending <= 1'b0;
         r_last_grant  <= 1'b1;
         r_drop        <= '0;
      end else begin
         if (w_xfer) begin
            r_last_grant <= w_g1;
            if (w_in_range) begin
               r_x      <= w_x;
               r_y      <= w_y;
               r_colour <= w_colour;
            end else if (r_drop != 16'hFFFF) begin
               r_drop <= r_drop + 16'd1;
            end
         end
         if (w_enter_clear) begin
            r_clr_pending <= 1'b0;
         end else if (clear_start && r_state != S_CLEAR) begin
            r_clr_pending <= 1'b1;
            r_clr_colour  <= clear_colour;
         end
         if (r_state != S_CLEAR) begin
            r_cx <= '0;
            r_cy <= '0;
         end else if (!avm_waitrequest) begin
            r_cx <= (r_cx == W_MAX) ? 8'd0 : r_cx + 8'd1;
            r_cy <= (r_cx == W_MAX) ? r_cy + 7'd1 : r_cy;
         end
      end
   end
endmodule

// File: tb/tb_vga_plot_arb.sv
// tb_vga_plot_arb: directed and randomized checks of vga_plot_arb against a transaction-level model
module tb_vga_plot_arb;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        r0_valid, r1_valid, r0_ready, r1_ready;
   logic [7:0]  r0_x, r1_x, r0_colour, r1_colour;
   logic [6:0]  r0_y, r1_y;
   logic        clear_start;
   logic [7:0]  clear_colour;
   logic        busy_clearing;
   logic [3:0]  avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [15:0] drop_count;

   int n_chk = 0;
   int n_fail = 0;

   vga_plot_arb dut (
      .clk(clk), .reset_n(reset_n),
      .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
      .r0_x(r0_x), .r0_y(r0_y), .r0_colour(r0_colour),
      .r1_x(r1_x), .r1_y(r1_y), .r1_colour(r1_colour),
      .clear_start(clear_start), .clear_colour(clear_colour), .busy_clearing(busy_clearing),
      .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pix(input int x, input int y, input int c);
      return {1'b0, 7'(y), 8'(x), 8'd0, 8'(c)};
   endfunction

   initial begin
      logic [31:0] q[$];
      logic [31:0] first_d, last_d, exp_d, prev_d;
      bit          hold[2];
      logic [7:0]  px[2], pc[2];
      logic [6:0]  py[2];
      int          n_wr, errs, k, g, model_last, drops, n_acc;
      bit          exp_g, prev_stall;
      reset_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b0;
      r0_x = '0; r0_y = '0; r0_colour = '0; r1_x = '0; r1_y = '0; r1_colour = '0;
      clear_start = 1'b0; clear_colour = '0; avm_waitrequest = 1'b0;
      #12;
      chk("reset_r0_ready", r0_ready, 0);
      chk("reset_r1_ready", r1_ready, 0);
      chk("reset_write", avm_write, 0);
      chk("reset_wdata", avm_writedata, 0);
      chk("reset_drop", drop_count, 0);
      chk("reset_busy", busy_clearing, 0);
      chk("reset_addr", avm_address, 0);
      r0_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      // single in-range write, no stall
      r0_valid = 1'b1; r0_x = 8'd50; r0_y = 7'd60; r0_colour = 8'hFF;
      #1;
      chk("w1_r0_ready", r0_ready, 1);
      chk("w1_r1_ready", r1_ready, 0);
      chk("w1_idle_write", avm_write, 0);
      tick();
      r0_valid = 1'b0;
      #1;
      chk("w1_write", avm_write, 1);
      chk("w1_wdata", avm_writedata, 32'h3C3200FF);
      chk("w1_r0_ready_issue", r0_ready, 0);
      tick();
      chk("w1_write_done", avm_write, 0);
      // both requesters held valid: grants alternate, r1 first since r0 went last
      r0_valid = 1'b1; r0_x = 8'd1; r0_y = 7'd2; r0_colour = 8'h11;
      r1_valid = 1'b1; r1_x = 8'd3; r1_y = 7'd4; r1_colour = 8'h22;
      exp_g = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_r1_ready", r1_ready, exp_g);
         chk("rr_r0_ready", r0_ready, !exp_g);
         tick();
         chk("rr_wdata", avm_writedata, exp_g ? pix(3, 4, 8'h22) : pix(1, 2, 8'h11));
         tick();
         exp_g = !exp_g;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      // out-of-range pixels are accepted and dropped
      r1_valid = 1'b1; r1_x = 8'd160; r1_y = 7'd10;
      #1;
      chk("drop1_ready", r1_ready, 1);
      tick();
      r1_x = 8'd5; r1_y = 7'd120;
      #1;
      chk("drop1_write", avm_write, 0);
      chk("drop1_count", drop_count, 1);
      chk("drop2_ready", r1_ready, 1);
      tick();
      r1_valid = 1'b0;
      #1;
      chk("drop2_count", drop_count, 2);
      chk("drop2_write", avm_write, 0);
      // stalled write: held for 3 waitrequest cycles plus the completing one
      r0_valid = 1'b1; r0_x = 8'd7; r0_y = 7'd8; r0_colour = 8'h5A;
      #1;
      chk("stall_ready", r0_ready, 1);
      tick();
      r0_valid = 1'b0; avm_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) avm_waitrequest = 1'b0;
         #1;
         chk("stall_write", avm_write, 1);
         chk("stall_wdata", avm_writedata, pix(7, 8, 8'h5A));
         tick();
      end
      chk("stall_idle", avm_write, 0);
      // clear beats a simultaneous request, then fills the screen
      r0_valid = 1'b1; clear_start = 1'b1; clear_colour = 8'h00;
      #1;
      chk("clr_r0_ready", r0_ready, 0);
      chk("clr_r1_ready", r1_ready, 0);
      tick();
      clear_start = 1'b0;
      #1;
      chk("clr_busy_pending", busy_clearing, 1);
      chk("clr_pending_write", avm_write, 0);
      tick();
      n_wr = 0; errs = 0; first_d = '1; last_d = '1;
      while (avm_write === 1'b1 && n_wr < 20000) begin
         if (avm_writedata !== pix(n_wr % 160, n_wr / 160, 0)) errs++;
         if (r0_ready || r1_ready || !busy_clearing) errs++;
         if (n_wr == 0) first_d = avm_writedata;
         last_d = avm_writedata;
         clear_start = (n_wr == 500);
         clear_colour = (n_wr == 500) ? 8'hAB : 8'h00;
         n_wr++;
         tick();
      end
      clear_start = 1'b0;
      chk("clr_count", n_wr, 19200);
      chk("clr_seq_errs", errs, 0);
      chk("clr_first", first_d, 32'h00000000);
      chk("clr_last", last_d, 32'h779F0000);
      chk("clr_busy_done", busy_clearing, 0);
      chk("clr_write_done", avm_write, 0);
      r0_valid = 1'b0;
      tick();
      // reset in the middle of a clear
      clear_start = 1'b1; clear_colour = 8'h33;
      tick();
      clear_start = 1'b0;
      k = 0;
      for (int c = 0; c < 300 && !(avm_write && k == 100); c++) begin
         if (avm_write) k++;
         tick();
      end
      chk("rst_mid_wdata", avm_writedata, pix(100, 0, 8'h33));
      reset_n = 1'b0;
      #1;
      chk("rst_mid_write", avm_write, 0);
      chk("rst_mid_busy", busy_clearing, 0);
      chk("rst_mid_drop", drop_count, 0);
      tick();
      tick();
      reset_n = 1'b1;
      n_wr = 0;
      for (int c = 0; c < 50; c++) begin
         if (avm_write || busy_clearing) n_wr++;
         tick();
      end
      chk("rst_no_writes", n_wr, 0);
      r0_valid = 1'b1; r1_valid = 1'b1;
      #1;
      chk("rst_grant_r0", r0_ready, 1);
      chk("rst_grant_r1", r1_ready, 0);
      r0_valid = 1'b0; r1_valid = 1'b0;
      tick();
      // randomized traffic against a transaction-level scoreboard
      model_last = 1; drops = 0; errs = 0; n_wr = 0; n_acc = 0;
      hold[0] = 0; hold[1] = 0; prev_stall = 0; prev_d = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!hold[i] && cyc < 1980 && $urandom_range(0, 1) == 1) begin
               hold[i] = 1;
               px[i] = 8'($urandom_range(0, 179));
               py[i] = 7'($urandom_range(0, 127));
               pc[i] = 8'($urandom);
            end
         end
         r0_valid = hold[0]; r0_x = px[0]; r0_y = py[0]; r0_colour = pc[0];
         r1_valid = hold[1]; r1_x = px[1]; r1_y = py[1]; r1_colour = pc[1];
         avm_waitrequest = (cyc < 1980) && ($urandom_range(0, 3) == 0);
         #1;
         if (r0_ready && r1_ready) errs++;
         if ((r0_ready && !hold[0]) || (r1_ready && !hold[1])) errs++;
         if ((r0_ready || r1_ready) && avm_write) errs++;
         if (avm_address !== 4'd0 || avm_writedata[31] !== 1'b0) errs++;
         if (r0_ready || r1_ready) begin
            g = r1_ready ? 1 : 0;
            if (hold[0] && hold[1] && g == model_last) errs++;
            model_last = g;
            if (px[g] < 160 && py[g] < 120) q.push_back(pix(px[g], py[g], pc[g]));
            else if (drops < 65535) drops++;
            hold[g] = 0;
            n_acc++;
         end
         if (avm_write) begin
            if (prev_stall && avm_writedata !== prev_d) errs++;
            if (!avm_waitrequest) begin
               if (q.size() == 0) errs++;
               else begin
                  exp_d = q.pop_front();
                  if (avm_writedata !== exp_d) errs++;
               end
               n_wr++;
            end
         end
         prev_stall = avm_write && avm_waitrequest;
         prev_d = avm_writedata;
         tick();
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      chk("rand_errs", errs, 0);
      chk("rand_queue_empty", q.size(), 0);
      chk("rand_drops", drop_count, drops);
      chk("rand_activity", n_acc > 100, 1);
      chk("rand_writes_seen", n_wr > 50, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
